// File: rtl/round_robin_arbiter_if.sv
// Request/grant bundle between requesting agents and the round-robin arbiter.
// The master side drives requests and ack; the slave (arbiter) returns the grant.
interface round_robin_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             en;
    logic [WIDTH-1:0] requests;
    logic             ack;
    logic [WIDTH-1:0] sel;
    logic [IDX_W-1:0] sel_idx;
    logic             busy;
    logic             timeout;

    modport master (
        output en, requests, ack,
        input  sel, sel_idx, busy, timeout
    );

    modport slave (
        input  en, requests, ack,
        output sel, sel_idx, busy, timeout
    );
endinterface

// File: rtl/round_robin_arbiter.sv
// Registered round-robin arbiter: rotating priority pointer, grant held until ack,
// request drop or hold-limit expiry, with zero-bubble handover to the next winner.
module round_robin_arbiter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned START    = 2,
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    round_robin_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned HCW   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {S_IDLE, S_GRANT} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] sel_q, sel_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [HCW-1:0]   hold_q, hold_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             held;
    logic             limit;
    logic             rel;
    logic [IDX_W-1:0] ptr_rel;
    logic [IDX_W:0]   win_idle;
    logic [IDX_W:0]   win_rel;

    // Returns {found, index} of the first set request scanning from p with wrap at WIDTH.
    function automatic logic [IDX_W:0] arbitrate(input logic [IDX_W-1:0] p,
                                                 input logic [WIDTH-1:0] req);
        logic [IDX_W:0]   r;
        logic [WIDTH-1:0] shifted;
        int unsigned      j;
        r = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            j = 32'(p) + i;
            if (j >= WIDTH) j = j - WIDTH;
            shifted = req >> j;
            if (!r[IDX_W] && shifted[0]) r = {1'b1, IDX_W'(j)};
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;

        held     = |(bus.requests & sel_q);
        limit    = (MAX_HOLD != 0) && (hold_q == HCW'(MAX_HOLD - 1));
        rel      = bus.ack || !held || limit;
        ptr_rel  = (idx_q == IDX_W'(WIDTH - 1)) ? '0 : idx_q + IDX_W'(1);
        win_idle = arbitrate(ptr_q, bus.requests);
        win_rel  = arbitrate(ptr_rel, bus.requests);

        // Disable aborts any grant without moving the pointer.
        if (!bus.en) begin
            state_d = S_IDLE;
            sel_d   = '0;
            idx_d   = '0;
            hold_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (win_idle[IDX_W]) begin
                        state_d = S_GRANT;
                        idx_d   = win_idle[IDX_W-1:0];
                        sel_d   = WIDTH'(1) << win_idle[IDX_W-1:0];
                        hold_d  = '0;
                    end
                end
                S_GRANT: begin
                    if (rel) begin
                        ptr_d     = ptr_rel;
                        timeout_d = limit && !bus.ack && held;
                        hold_d    = '0;
                        // Re-arbitrate from the advanced pointer so handover has no bubble.
                        if (win_rel[IDX_W]) begin
                            idx_d = win_rel[IDX_W-1:0];
                            sel_d = WIDTH'(1) << win_rel[IDX_W-1:0];
                        end else begin
                            state_d = S_IDLE;
                            idx_d   = '0;
                            sel_d   = '0;
                        end
                    end else begin
                        hold_d = hold_q + HCW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = |sel_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= IDX_W'(START);
            sel_q     <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.sel_idx = idx_q;
    assign bus.busy    = busy_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_round_robin_arbiter.sv
// Bench for round_robin_arbiter: vector tables for a WIDTH=4 and a WIDTH=5 instance,
// expected outputs queued at drive time and popped after the following clock edge.
module tb_round_robin_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    round_robin_arbiter_if #(.WIDTH(4)) if4 ();
    round_robin_arbiter_if #(.WIDTH(5)) if5 ();

    round_robin_arbiter #(.WIDTH(4), .START(2), .MAX_HOLD(8)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(if4)
    );
    round_robin_arbiter #(.WIDTH(5), .START(4), .MAX_HOLD(8)) dut5 (
        .clk(clk), .rst_n(rst_n), .bus(if5)
    );

    typedef struct {
        bit         w5;
        logic       en;
        logic [4:0] req;
        logic       ack;
        logic [4:0] sel;
        logic [2:0] idx;
        logic       busy;
        logic       to;
        string      name;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic void add(bit w5, logic en, logic [4:0] req, logic ack,
                                logic [4:0] sel, logic [2:0] idx, logic to, string name);
        vec_t v;
        v.w5 = w5; v.en = en; v.req = req; v.ack = ack;
        v.sel = sel; v.idx = idx; v.busy = |sel; v.to = to; v.name = name;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic compare(input vec_t e);
        logic [4:0] a_sel;
        logic [2:0] a_idx;
        logic       a_busy, a_to;
        if (e.w5) begin
            a_sel = if5.sel; a_idx = if5.sel_idx; a_busy = if5.busy; a_to = if5.timeout;
        end else begin
            a_sel = {1'b0, if4.sel}; a_idx = {1'b0, if4.sel_idx};
            a_busy = if4.busy; a_to = if4.timeout;
        end
        n_checks++;
        if (a_sel === e.sel && a_idx === e.idx && a_busy === e.busy && a_to === e.to)
            n_pass++;
        else
            $display("FAIL %s: got sel=%b idx=%0d busy=%b to=%b expected sel=%b idx=%0d busy=%b to=%b",
                     e.name, a_sel, a_idx, a_busy, a_to, e.sel, e.idx, e.busy, e.to);
    endtask

    task automatic zero_inputs();
        if4.en = 1'b0; if4.requests = '0; if4.ack = 1'b0;
        if5.en = 1'b0; if5.requests = '0; if5.ack = 1'b0;
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        if (v.w5) begin
            if5.en = v.en; if5.requests = v.req; if5.ack = v.ack;
        end else begin
            if4.en = v.en; if4.requests = v.req[3:0]; if4.ack = v.ack;
        end
        sb.push_back(v);
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    task automatic run_vecs();
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
        vecs.delete();
    endtask

    task automatic do_reset(string name);
        @(negedge clk);
        zero_inputs();
        rst_n = 1'b0;
        #1;
        check({name, "_sel4"},  32'(if4.sel), 32'd0);
        check({name, "_busy4"}, 32'(if4.busy), 32'd0);
        check({name, "_idx4"},  32'(if4.sel_idx), 32'd0);
        check({name, "_to4"},   32'(if4.timeout), 32'd0);
        check({name, "_sel5"},  32'(if5.sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        zero_inputs();
        #1;
        check("por_sel", 32'(if4.sel), 32'd0);
        check("por_to",  32'(if4.timeout), 32'd0);
        do_reset("rst0");

        // Rotation from ptr=START=2 with ack every grant cycle.
        add(0, 1, 5'b01111, 0, 5'b00100, 3'd2, 0, "rot0");
        add(0, 1, 5'b01111, 1, 5'b01000, 3'd3, 0, "rot1");
        add(0, 1, 5'b01111, 1, 5'b00001, 3'd0, 0, "rot2");
        add(0, 1, 5'b01111, 1, 5'b00010, 3'd1, 0, "rot3");
        add(0, 1, 5'b01111, 1, 5'b00100, 3'd2, 0, "rot4");
        add(0, 1, 5'b00000, 1, 5'b00000, 3'd0, 0, "rot_idle");
        run_vecs();

        // Skip and wrap.
        do_reset("rst1");
        add(0, 1, 5'b00011, 0, 5'b00001, 3'd0, 0, "skip0");
        add(0, 1, 5'b00011, 1, 5'b00010, 3'd1, 0, "skip1");
        add(0, 1, 5'b00000, 1, 5'b00000, 3'd0, 0, "skip_idle");
        run_vecs();

        // Hold limit: 8 visible cycles, then forced release with timeout.
        do_reset("rst2");
        add(0, 1, 5'b00101, 0, 5'b00100, 3'd2, 0, "hold_g");
        for (int i = 0; i < 7; i++) add(0, 1, 5'b00101, 0, 5'b00100, 3'd2, 0, "hold_keep");
        add(0, 1, 5'b00101, 0, 5'b00001, 3'd0, 1, "hold_force");
        add(0, 1, 5'b00101, 0, 5'b00001, 3'd0, 0, "hold_after");
        add(0, 1, 5'b00100, 1, 5'b00100, 3'd2, 0, "sole_g");
        for (int i = 0; i < 7; i++) add(0, 1, 5'b00100, 0, 5'b00100, 3'd2, 0, "sole_keep");
        add(0, 1, 5'b00100, 0, 5'b00100, 3'd2, 1, "sole_force");
        add(0, 1, 5'b00000, 0, 5'b00000, 3'd0, 0, "sole_drop");
        run_vecs();

        // Request drop (ptr=3), then ack coinciding with the limit.
        add(0, 1, 5'b01001, 0, 5'b01000, 3'd3, 0, "drop_g");
        add(0, 1, 5'b00001, 0, 5'b00001, 3'd0, 0, "drop_rel");
        add(0, 1, 5'b00000, 0, 5'b00000, 3'd0, 0, "drop_idle");
        add(0, 1, 5'b00010, 0, 5'b00010, 3'd1, 0, "sim_g");
        for (int i = 0; i < 7; i++) add(0, 1, 5'b00010, 0, 5'b00010, 3'd1, 0, "sim_keep");
        add(0, 1, 5'b00010, 1, 5'b00010, 3'd1, 0, "sim_ack_limit");
        add(0, 1, 5'b00000, 0, 5'b00000, 3'd0, 0, "sim_idle");
        run_vecs();

        // Abort mid-grant of 1000: pointer must not advance.
        do_reset("rst3");
        add(0, 1, 5'b00100, 0, 5'b00100, 3'd2, 0, "ab_g0");
        add(0, 1, 5'b01000, 1, 5'b01000, 3'd3, 0, "ab_g1");
        add(0, 0, 5'b01111, 0, 5'b00000, 3'd0, 0, "ab_off");
        add(0, 0, 5'b01111, 0, 5'b00000, 3'd0, 0, "ab_off_req");
        add(0, 1, 5'b00000, 1, 5'b00000, 3'd0, 0, "ab_idle_ack");
        add(0, 1, 5'b01111, 0, 5'b01000, 3'd3, 0, "ab_regrant");
        run_vecs();

        // Asynchronous reset mid-grant, then first grant follows START.
        add(0, 1, 5'b01111, 1, 5'b00001, 3'd0, 0, "rm_g");
        run_vecs();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rm_async_sel",  32'(if4.sel), 32'd0);
        check("rm_async_busy", 32'(if4.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        add(0, 1, 5'b01111, 0, 5'b00100, 3'd2, 0, "rm_first");
        run_vecs();

        // Non-power-of-2 wrap on the WIDTH=5, START=4 instance.
        do_reset("rst4");
        add(1, 1, 5'b10001, 0, 5'b10000, 3'd4, 0, "w5_0");
        add(1, 1, 5'b10001, 1, 5'b00001, 3'd0, 0, "w5_1");
        add(1, 1, 5'b10001, 1, 5'b10000, 3'd4, 0, "w5_2");
        add(1, 1, 5'b00000, 1, 5'b00000, 3'd0, 0, "w5_idle");
        run_vecs();

        if (sb.size() != 0) check("sb_empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
